// File: rtl/axil_mem_responder.sv
// AXI4-Lite slave over a small word memory with saturating SLVERR counter; write commits one edge after the later of AW/W, read data one edge after AR.
// Backpressure: one AW and one W are held while B is stalled; ARREADY drops while R is pending.
module axil_mem_responder #(
  parameter int                        C_DATA_WIDTH = 32,
  parameter int                        C_ADDR_WIDTH = 32,
  parameter logic [C_ADDR_WIDTH-1:0]   C_BASE_ADDR  = 32'h4000_0000,
  parameter int                        C_DEPTH      = 16
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [C_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                S_AXI_AWPROT,
  input  logic                      S_AXI_AWVALID,
  output logic                      S_AXI_AWREADY,
  input  logic [C_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                      S_AXI_WVALID,
  output logic                      S_AXI_WREADY,
  output logic [1:0]                S_AXI_BRESP,
  output logic                      S_AXI_BVALID,
  input  logic                      S_AXI_BREADY,
  input  logic [C_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                S_AXI_ARPROT,
  input  logic                      S_AXI_ARVALID,
  output logic                      S_AXI_ARREADY,
  output logic [C_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                S_AXI_RRESP,
  output logic                      S_AXI_RVALID,
  input  logic                      S_AXI_RREADY,
  output logic [7:0]                ERR_COUNT
);

  localparam int                      IDX_W = $clog2(C_DEPTH);
  localparam int                      NB    = C_DATA_WIDTH / 8;
  localparam logic [C_ADDR_WIDTH-1:0] SPAN  = C_ADDR_WIDTH'(4 * C_DEPTH);

  logic [C_DATA_WIDTH-1:0] mem [C_DEPTH];

  logic                    rst_done;
  logic                    aw_full;
  logic [C_ADDR_WIDTH-1:0] aw_addr;
  logic                    w_full;
  logic [C_DATA_WIDTH-1:0] w_data;
  logic [NB-1:0]           w_strb;
  logic                    bvalid;
  logic [1:0]              bresp;
  logic                    rvalid;
  logic [C_DATA_WIDTH-1:0] rdata;
  logic [1:0]              rresp;
  logic [7:0]              err_count;

  logic                    aw_hs, w_hs, ar_hs, commit;
  logic [C_ADDR_WIDTH-1:0] aw_off, ar_off;
  logic                    aw_hit, ar_hit;
  logic [IDX_W-1:0]        aw_idx, ar_idx;
  logic                    wr_err, rd_err;
  logic [8:0]              err_sum;
  logic                    unused_prot;

  // Unsigned wrap makes addresses below the base land far outside SPAN.
  assign aw_off = aw_addr - C_BASE_ADDR;
  assign ar_off = S_AXI_ARADDR - C_BASE_ADDR;
  assign aw_hit = aw_off < SPAN;
  assign ar_hit = ar_off < SPAN;
  assign aw_idx = aw_off[IDX_W+1:2];
  assign ar_idx = ar_off[IDX_W+1:2];

  // rst_done keeps every READY low until the first edge after reset release.
  assign S_AXI_AWREADY = rst_done && !aw_full;
  assign S_AXI_WREADY  = rst_done && !w_full;
  assign S_AXI_ARREADY = rst_done && !rvalid;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = bresp;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_RRESP   = rresp;
  assign ERR_COUNT     = err_count;

  assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign commit = aw_full && w_full && (!bvalid || S_AXI_BREADY);
  assign wr_err = commit && !aw_hit;
  assign rd_err = ar_hs && !ar_hit;

  assign err_sum     = {1'b0, err_count} + {8'd0, wr_err} + {8'd0, rd_err};
  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rst_done <= 1'b0;
      aw_full  <= 1'b0;
      aw_addr  <= '0;
      w_full   <= 1'b0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid   <= 1'b0;
      bresp    <= 2'b00;
    end else begin
      rst_done <= 1'b1;
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_addr <= S_AXI_AWADDR;
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      // commit needs both holders full, so it never coincides with a new beat.
      if (commit) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= aw_hit ? 2'b00 : 2'b10;
      end else if (bvalid && S_AXI_BREADY) begin
        bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < C_DEPTH; i++) mem[i] <= '0;
    end else if (commit && aw_hit) begin
      for (int b = 0; b < NB; b++)
        if (w_strb[b]) mem[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
    end
  end

  // Sampling mem here on a commit edge returns the pre-write word.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= 2'b00;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rdata  <= ar_hit ? mem[ar_idx] : '0;
      rresp  <= ar_hit ? 2'b00 : 2'b10;
    end else if (rvalid && S_AXI_RREADY) begin
      rvalid <= 1'b0;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) err_count <= 8'd0;
    else        err_count <= err_sum[8] ? 8'hFF : err_sum[7:0];
  end

endmodule

// File: tb/tb_axil_mem_responder.sv
// Randomized AXI-Lite traffic against a transaction-level memory/error model, plus directed corner cases.
module tb_axil_mem_responder;

  localparam logic [31:0] BASE   = 32'h4000_0000;
  localparam longint      BASE_L = 64'h4000_0000;
  localparam int          DEPTH  = 16;
  localparam logic [31:0] OOR    = BASE + 32'(4 * DEPTH);

  logic        tb_ACLK = 1'b0;
  logic        areset;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [7:0]  err_count;

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [31:0] model_mem [DEPTH];
  int          model_err;

  always #5 tb_ACLK = ~tb_ACLK;

  axil_mem_responder dut (
    .ACLK(tb_ACLK), .ARESET(areset),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .ERR_COUNT(err_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic hit(input logic [31:0] a);
    longint la = {32'd0, a};
    return (la >= BASE_L) && (la < BASE_L + 4 * DEPTH);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic void bump_err(input int n);
    model_err = (model_err + n > 255) ? 255 : model_err + n;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (hit(a)) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) model_mem[widx(a)][8*b +: 8] = d[8*b +: 8];
    end else begin
      bump_err(1);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
    model_err = 0;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0: return OOR + 32'($urandom_range(0, 255));
      1: return BASE - 32'd1 - 32'($urandom_range(0, 255));
      2: return $urandom() & 32'h3FFF_FFFF;
      default: return BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
    endcase
  endfunction

  // All tasks start and end #1 after a rising edge.
  task automatic step();
    @(posedge tb_ACLK);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly);
    logic       aw_done, w_done, aw_go, w_go;
    logic [1:0] exp_resp;
    int         cyc, bcyc;
    exp_resp = hit(a) ? 2'b00 : 2'b10;
    awaddr = a; wdata = d; wstrb = s; bready = 1'b0;
    aw_done = 1'b0; w_done = 1'b0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 64) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      aw_go = awvalid && awready;
      w_go  = wvalid && wready;
      step();
      cyc++;
      if (aw_go) aw_done = 1'b1;
      if (w_go)  w_done  = 1'b1;
      if (w_done && !aw_done) check("wready_held_low", {31'd0, wready}, 32'd0);
      if (aw_done && !w_done) check("awready_held_low", {31'd0, awready}, 32'd0);
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("wr_handshake", {30'd0, aw_done, w_done}, 32'd3);
    bcyc = 0;
    while (!bvalid && bcyc < 64) begin
      step();
      bcyc++;
    end
    check("b_latency", bcyc, 32'd1);
    check("bresp", {30'd0, bresp}, {30'd0, exp_resp});
    for (int i = 0; i < b_dly; i++) begin
      step();
      check("b_hold", {29'd0, bvalid, bresp}, {29'd0, 1'b1, exp_resp});
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
    check("b_single", {31'd0, bvalid}, 32'd0);
    model_write(a, d, s);
    check("err_count_wr", {24'd0, err_count}, model_err);
  endtask

  task automatic axi_read(input logic [31:0] a, input int r_dly);
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    logic        done, go;
    int          cyc;
    exp_data = hit(a) ? model_mem[widx(a)] : 32'd0;
    exp_resp = hit(a) ? 2'b00 : 2'b10;
    araddr = a; arvalid = 1'b1; rready = 1'b0;
    done = 1'b0; cyc = 0;
    while (!done && cyc < 64) begin
      go = arvalid && arready;
      step();
      cyc++;
      if (go) done = 1'b1;
    end
    arvalid = 1'b0;
    check("ar_handshake", {31'd0, done}, 32'd1);
    check("r_latency", {31'd0, rvalid}, 32'd1);
    check("rdata", rdata, exp_data);
    check("rresp", {30'd0, rresp}, {30'd0, exp_resp});
    if (!hit(a)) bump_err(1);
    check("err_count_rd", {24'd0, err_count}, model_err);
    for (int i = 0; i < r_dly; i++) begin
      step();
      check("r_hold", {rdata[29:0], rresp}, {exp_data[29:0], exp_resp});
    end
    rready = 1'b1;
    step();
    rready = 1'b0;
    check("r_single", {31'd0, rvalid}, 32'd0);
  endtask

  // Write commit and AR handshake land on the same edge.
  task automatic same_edge(input logic [31:0] wa, input logic [31:0] wd, input logic [31:0] ra);
    logic [31:0] exp_data;
    exp_data = hit(ra) ? model_mem[widx(ra)] : 32'd0;
    awaddr = wa; wdata = wd; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    bready = 1'b0; rready = 1'b0;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = ra; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    check("se_bvalid", {31'd0, bvalid}, 32'd1);
    check("se_bresp", {30'd0, bresp}, hit(wa) ? 32'd0 : 32'd2);
    check("se_rvalid", {31'd0, rvalid}, 32'd1);
    check("se_rdata_old", rdata, exp_data);
    check("se_rresp", {30'd0, rresp}, hit(ra) ? 32'd0 : 32'd2);
    model_write(wa, wd, 4'hF);
    if (!hit(ra)) bump_err(1);
    check("se_err_count", {24'd0, err_count}, model_err);
    bready = 1'b1; rready = 1'b1;
    step();
    bready = 1'b0; rready = 1'b0;
    check("se_idle", {30'd0, bvalid, rvalid}, 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    model_reset();
    repeat (3) step();
    check("rst_readys", {29'd0, awready, wready, arready}, 32'd0);
    check("rst_valids", {30'd0, bvalid, rvalid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_resps", {28'd0, bresp, rresp}, 32'd0);
    check("rst_err", {24'd0, err_count}, 32'd0);
    areset = 1'b0;
    step();
    check("post_rst_readys", {29'd0, awready, wready, arready}, 32'd7);

    axi_write(BASE, 32'h0101FFFF, 4'hF, 0, 0, 0);
    axi_read(BASE, 0);
    check("tp_full_word", rdata, 32'h0101FFFF);

    axi_write(BASE + 4, 32'hBEEFCAFE, 4'hF, 0, 0, 0);
    axi_write(BASE + 4, 32'hDEAD0011, 4'b0011, 0, 0, 1);
    axi_read(BASE + 4, 0);
    check("tp_strobe_merge", rdata, 32'hBEEF0011);

    axi_write(OOR, 32'h12345678, 4'hF, 0, 0, 0);
    axi_read(32'h0000_0000, 0);
    check("tp_err_two", {24'd0, err_count}, 32'd2);

    axi_write(BASE + 8, 32'hABCD0001, 4'hF, 3, 0, 0);
    axi_read(BASE + 8, 1);
    check("tp_w_first", rdata, 32'hABCD0001);

    // B stalled across two writes.
    awaddr = BASE + 12; wdata = 32'h1234_5678; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    step();
    check("bp_ready_low_held", {30'd0, awready, wready}, 32'd0);
    awaddr = OOR + 8; wdata = 32'h5555_AAAA;
    step();
    check("bp_b1_valid", {29'd0, bvalid, bresp}, 32'd4);
    model_write(BASE + 12, 32'h1234_5678, 4'hF);
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("bp_b1_stable", {29'd0, bvalid, bresp}, 32'd4);
      check("bp_ready_low", {30'd0, awready, wready}, 32'd0);
      step();
    end
    bready = 1'b1;
    step();
    model_write(OOR + 8, 32'h5555_AAAA, 4'hF);
    check("bp_b2_valid", {29'd0, bvalid, bresp}, 32'd6);
    check("bp_ready_back", {30'd0, awready, wready}, 32'd3);
    check("bp_err", {24'd0, err_count}, model_err);
    step();
    bready = 1'b0;
    check("bp_b_done", {31'd0, bvalid}, 32'd0);

    same_edge(BASE + 20, 32'hCAFE_F00D, BASE + 20);
    same_edge(BASE + 20, 32'h0BAD_BEEF, BASE + 20);
    same_edge(OOR, 32'h1, BASE - 4);

    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 1) == 1)
        axi_write(rand_addr(), $urandom(), 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      else
        axi_read(rand_addr(), $urandom_range(0, 2));
    end

    for (int i = 0; i < DEPTH; i++) axi_read(BASE + 32'(4 * i), 0);

    for (int n = 0; n < 260; n++) axi_read(OOR + 32'($urandom_range(0, 1023)), 0);
    check("sat_err", {24'd0, err_count}, 32'd255);
    same_edge(OOR + 4, 32'h2, BASE - 8);

    // Reset with both responses pending.
    awaddr = BASE + 16; wdata = 32'h7777_7777; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = BASE; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    step();
    check("pre_rst_pending", {30'd0, bvalid, rvalid}, 32'd3);
    areset = 1'b1;
    #1;
    check("rst_drop_valids", {30'd0, bvalid, rvalid}, 32'd0);
    check("rst_drop_err", {24'd0, err_count}, 32'd0);
    check("rst_drop_ready", {29'd0, awready, wready, arready}, 32'd0);
    model_reset();
    step();
    areset = 1'b0;
    bready = 1'b1; rready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_quiet", {30'd0, bvalid, rvalid}, 32'd0);
    end
    bready = 1'b0; rready = 1'b0;
    for (int i = 0; i < DEPTH; i++) axi_read(BASE + 32'(4 * i), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
